bp_me_mem_cmd_stream_to_lite: RTL

- Downstream consumer of the BedRock memory-command stream; sits between a CCE/LCE stream producer and a memory-side lite endpoint that takes one header plus full data per message.
- Collects header + N narrow data beats into one wide message.
- Decides whether data beats follow from mem_cmd_payload_mask_gp.
- Sizes the beat count from the header size field.

---
 rtl/bp_me_mem_cmd_stream_to_lite_pkg.sv | 57 +++++
 rtl/bp_me_mem_cmd_stream_to_lite_beat_counter.sv | 61 ++++++
 rtl/bp_me_mem_cmd_stream_to_lite.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bp_me_mem_cmd_stream_to_lite_pkg.sv
// Shared types for the BedRock memory-command stream-to-lite converter.
//  - Proc config selector and physical address width.
//  - BedRock memory header layout with its message-type and size enums.
//  - mem_cmd_payload_mask_gp: bit per msg_type, set when data beats follow.
//  - Stream-collector state encoding, shared with the response-side
//    lite-to-stream block.
package bp_me_mem_cmd_stream_to_lite_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg     = 2'd0,
    e_bp_unicore_cfg     = 2'd1,
    e_bp_multicore_1_cfg = 2'd2
  } bp_params_e;

  localparam int paddr_width_p = 40;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  // Message size is log2(bytes).
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [7:0]               payload;   // opaque routing / AMO info
    bp_bedrock_msg_size_e     size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               subop;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  // Writes (cached and uncached) and AMOs carry data beats.
  localparam logic [15:0] mem_cmd_payload_mask_gp =
    (16'd1 << e_bedrock_mem_wr) | (16'd1 << e_bedrock_mem_uc_wr) | (16'd1 << e_bedrock_mem_amo);

  typedef enum logic [1:0] {
    e_reset   = 2'd0,
    e_ready   = 2'd1,
    e_collect = 2'd2,
    e_send    = 2'd3
  } bp_me_stream_state_e;

endpackage

// File: rtl/bp_me_mem_cmd_stream_to_lite_beat_counter.sv
// bp_me_stream_beat_counter: derives the beat count of a stream message from
// its header and tracks the current beat.
//  clk_i, reset_n_i  clock, synchronous active-low reset
//  msg_type_i        header message type (selects payload / no payload)
//  size_i            header size, log2(bytes)
//  up_i              a beat is accepted this cycle
//  payload_o         message carries data beats
//  cnt_o             index of the current beat within the message
//  final_o           current beat is the last one of the message
//  oversize_o        payload larger than the lite width (beats saturated)
module bp_me_stream_beat_counter
  import bp_me_mem_cmd_stream_to_lite_pkg::*;
#(
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512,
  localparam int max_beats_lp    = out_data_width_p / in_data_width_p,
  localparam int cnt_width_lp    = $clog2(max_beats_lp) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  bp_bedrock_mem_type_e    msg_type_i,
  input  bp_bedrock_msg_size_e    size_i,
  input  logic                    up_i,
  output logic                    payload_o,
  output logic [cnt_width_lp-1:0] cnt_o,
  output logic                    final_o,
  output logic                    oversize_o
);

  localparam int lg_in_lp  = $clog2(in_data_width_p);
  localparam int lg_out_lp = $clog2(out_data_width_p);

  logic [cnt_width_lp-1:0] cnt_r;
  logic [cnt_width_lp-1:0] beats;
  int                      bits_lg;

  // Work in the log domain: message bits = 2^(size+3).
  always_comb begin
    payload_o  = mem_cmd_payload_mask_gp[msg_type_i];
    bits_lg    = int'(size_i) + 3;
    oversize_o = payload_o && (bits_lg > lg_out_lp);
    beats      = cnt_width_lp'(1);
    if (payload_o) begin
      if (bits_lg > lg_out_lp)
        beats = cnt_width_lp'(max_beats_lp);
      else if (bits_lg > lg_in_lp)
        beats = cnt_width_lp'(1) << (bits_lg - lg_in_lp);
    end
  end

  assign final_o = (cnt_r == (beats - cnt_width_lp'(1)));
  assign cnt_o   = cnt_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      cnt_r <= '0;
    else if (up_i)
      cnt_r <= final_o ? '0 : cnt_r + cnt_width_lp'(1);
  end

endmodule

// File: rtl/bp_me_mem_cmd_stream_to_lite.sv
// bp_me_mem_cmd_stream_to_lite: collects a BedRock memory-command stream
// (header + N narrow data beats) into one lite message (header + full data).
//  clk_i, reset_n_i   clock, synchronous active-low reset
//  in_header_i        stream header, stable for every beat of a message
//  in_data_i          stream data beat
//  in_v_i, in_last_i  beat valid, producer's end-of-message marker
//  in_ready_and_o     beat ready
//  out_header_o       registered header
//  out_data_o         assembled payload (narrow payloads replicated)
//  out_v_o            message valid
//  out_ready_and_i    consumer ready
// Handshakes are ready-and-valid: a beat transfers on a cycle where both
// in_v_i and in_ready_and_o are high, a message transfers on a cycle where
// both out_v_o and out_ready_and_i are high; valid never waits on ready.
module bp_me_mem_cmd_stream_to_lite
  import bp_me_mem_cmd_stream_to_lite_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int in_data_width_p        = 64,
  parameter int out_data_width_p       = 512,
  localparam int header_width_lp       = $bits(bp_bedrock_mem_header_s)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [header_width_lp-1:0]  in_header_i,
  input  logic [in_data_width_p-1:0]  in_data_i,
  input  logic                        in_v_i,
  input  logic                        in_last_i,
  output logic                        in_ready_and_o,
  output logic [header_width_lp-1:0]  out_header_o,
  output logic [out_data_width_p-1:0] out_data_o,
  output logic                        out_v_o,
  input  logic                        out_ready_and_i
);

  localparam int max_beats_lp = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = $clog2(max_beats_lp) + 1;
  localparam int lg_out_lp    = $clog2(out_data_width_p);

  if (bp_params_p != e_bp_default_cfg) begin : g_cfg_check
    $error("bp_me_mem_cmd_stream_to_lite: only the default proc config is supported");
  end
  if ((in_data_width_p < 8) || ((in_data_width_p & (in_data_width_p - 1)) != 0)) begin : g_in_check
    $error("in_data_width_p must be a power of two, at least 8");
  end
  if ((out_data_width_p < in_data_width_p) || ((out_data_width_p & (out_data_width_p - 1)) != 0)) begin : g_out_check
    $error("out_data_width_p must be a power of two, at least in_data_width_p");
  end

  bp_bedrock_mem_header_s  in_header;
  bp_bedrock_mem_header_s  header_r;
  logic [out_data_width_p-1:0] data_r;
  bp_me_stream_state_e     state_r, state_n;

  logic                    accept;
  logic                    beat_payload;
  logic [cnt_width_lp-1:0] beat_cnt;
  logic                    beat_final;
  logic                    beat_oversize;

  assign in_header = bp_bedrock_mem_header_s'(in_header_i);

  // Reset gates both handshakes so a message in flight is never exchanged
  // while reset_n_i is low.
  assign accept = reset_n_i & in_v_i & ((state_r == e_ready) | (state_r == e_collect));

  // The header is stable across the message, so the live header sizes the
  // count from the very first beat.
  bp_me_stream_beat_counter #(
    .in_data_width_p (in_data_width_p),
    .out_data_width_p(out_data_width_p)
  ) beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .msg_type_i(in_header.msg_type),
    .size_i    (in_header.size),
    .up_i      (accept),
    .payload_o (beat_payload),
    .cnt_o     (beat_cnt),
    .final_o   (beat_final),
    .oversize_o(beat_oversize)
  );

  always_comb begin
    state_n        = state_r;
    in_ready_and_o = 1'b0;
    out_v_o        = 1'b0;
    case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        in_ready_and_o = reset_n_i;
        if (accept) state_n = beat_final ? e_send : e_collect;
      end
      e_collect: begin
        in_ready_and_o = reset_n_i;
        if (accept && beat_final) state_n = e_send;
      end
      e_send: begin
        out_v_o = reset_n_i;
        if (out_ready_and_i) state_n = e_ready;
      end
      default: state_n = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      state_r <= e_reset;
    else
      state_r <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      header_r <= '0;
      data_r   <= '0;
    end else if (accept) begin
      if (state_r == e_ready) header_r <= in_header;
      if (beat_payload) begin
        for (int k = 0; k < max_beats_lp; k++) begin
          if (beat_cnt == cnt_width_lp'(k))
            data_r[k*in_data_width_p +: in_data_width_p] <= in_data_i;
        end
      end
    end
  end

  // Narrow payloads are replicated across the lite width: output bit i takes
  // bit (i mod message_bits), realised as an address mask on the bit index.
  int                   send_bits_lg;
  logic [lg_out_lp-1:0] rep_mask;

  always_comb begin
    send_bits_lg = int'(header_r.size) + 3;
    if (send_bits_lg > lg_out_lp) send_bits_lg = lg_out_lp;
    rep_mask   = {lg_out_lp{1'b1}} >> (lg_out_lp - send_bits_lg);
    out_data_o = '0;
    if (mem_cmd_payload_mask_gp[header_r.msg_type]) begin
      for (int i = 0; i < out_data_width_p; i++)
        out_data_o[i] = data_r[lg_out_lp'(i) & rep_mask];
    end
  end

  assign out_header_o = header_r;

  // Hardware trusts the header; these only flag inconsistent producers.
  last_matches_header: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    accept |-> (in_last_i == beat_final))
    else $warning("in_last_i disagrees with the header-derived final beat");

  size_within_lite: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    accept |-> !beat_oversize)
    else $warning("payload size exceeds lite width, beat count saturated");

endmodule
